// File: rtl/ram_pkg.sv
// Shared constants and types for the 64x8 registered-read RAM and its FIFO controller.
package ram_pkg;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding
// producer / consumer / RAM. Macro RAM_FIFO_CTRL_LEVEL_EN adds level/almost_full.
interface ram_fifo_ctrl_if #(
  parameter int DW = ram_pkg::DW,
  parameter int AW = ram_pkg::AW
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          ram_we;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data_out;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  modport slave (
    input  in_data, in_valid, out_ready, ram_data_out,
    output in_ready, out_data, out_valid,
    output ram_we, ram_write_addr, ram_data_in, ram_read_addr
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    , output level, almost_full
`endif
  );

  modport master (
    output in_data, in_valid, out_ready, ram_data_out,
    input  in_ready, out_data, out_valid,
    input  ram_we, ram_write_addr, ram_data_in, ram_read_addr
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    , input level, almost_full
`endif
  );

endinterface

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM pointer with increment enable; wraps naturally modulo 2**AW.
module ram_fifo_ptr #(
  parameter int AW = ram_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Advance by one on inc; the top bit simply carries out on 63 -> 0.
  always_comb begin
    ptr_d = '0;
    if (rst_n) begin
      ptr_d = ptr_q + AW'(inc);
    end
  end

  // Pointer register, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 64x8 RAM with one-cycle registered read.
// The RAM read address is steered to the post-edge head so ram_data_out is
// always the current head word; out_valid only counts words written before
// the previous edge, so a location is never read on the edge it is written.
// Optional macro RAM_FIFO_CTRL_LEVEL_EN adds level and almost_full outputs.
module ram_fifo_ctrl #(
  parameter int AW = ram_pkg::AW
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  , parameter int AF_LVL = 60
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_fifo_ctrl_if.slave  bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(2 ** AW);

  logic          push;
  logic          pop;
  logic          full;
  logic          in_ready;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          out_valid_q;
  logic          out_valid_d;

  ram_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  ram_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Handshakes and the look-ahead read address that keeps data_out on the head.
  always_comb begin
    full       = (count_q == DEPTH_CNT);
    in_ready   = rst_n & ~full;
    push       = bus.in_valid & in_ready;
    pop        = out_valid_q & bus.out_ready;
    rd_ptr_nxt = rd_ptr + AW'(pop);
  end

  // Occupancy and head-valid; out_valid uses pre-edge count so a word just written stays hidden one edge.
  always_comb begin
    count_d     = '0;
    out_valid_d = 1'b0;
    if (rst_n) begin
      count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
      out_valid_d = ((count_q - (AW+1)'(pop)) != '0);
    end
  end

  // Control state registers, synchronous active-low reset folded into the _d terms.
  always_ff @(posedge clk) begin
    count_q     <= count_d;
    out_valid_q <= out_valid_d;
  end

  // Drive the stream side and the RAM ports.
  always_comb begin
    bus.in_ready       = in_ready;
    bus.out_valid      = out_valid_q;
    bus.out_data       = bus.ram_data_out;
    bus.ram_we         = push;
    bus.ram_write_addr = wr_ptr;
    bus.ram_data_in    = bus.in_data;
    bus.ram_read_addr  = rd_ptr_nxt;
  end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LVL);

  logic almost_full_q;
  logic almost_full_d;

  // Almost-full looks at the post-edge count so it lines up with level.
  always_comb begin
    almost_full_d = rst_n & (count_d >= AF_CNT);
  end

  // Almost-full flag register.
  always_ff @(posedge clk) begin
    almost_full_q <= almost_full_d;
  end

  // Level and almost-full outputs.
  always_comb begin
    bus.level       = count_q;
    bus.almost_full = almost_full_q;
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: models the 64x8 registered-read RAM, runs a short
// vector table plus directed and randomized sequences against a queue model.
module tb_ram_fifo_ctrl;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ram_fifo_ctrl #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural RAM: write and registered read on the same edge, read returns old contents.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_read_addr];
  end

  int checks = 0;
  int passed = 0;

  // Reference model: queue of accepted bytes plus the visible-head flag.
  logic [DW-1:0] q [$];
  bit            m_ov = 1'b0;
  bit            m_af = 1'b0;
  int            m_pushes = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: compare against the model at negedge, then advance the model at posedge.
  task automatic tick();
    bit p, o, stall;
    logic [DW-1:0] d;
    int sz;
    @(negedge clk);
    sz = q.size();
    chk("in_ready", bus.in_ready, (rst_n && sz < DEPTH) ? 1 : 0);
    chk("out_valid", bus.out_valid, m_ov);
    p = bus.in_valid && rst_n && (sz < DEPTH);
    o = m_ov && bus.out_ready && rst_n;
    chk("ram_we", bus.ram_we, p);
    if (m_ov) begin
      if (sz > 0) chk("out_data", bus.out_data, q[0]);
      else chk("model_head", 1, 0);
    end
    if (prev_stall) chk("stall_hold", bus.out_data, prev_data);
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    chk("level", bus.level, sz);
    chk("almost_full", bus.almost_full, m_af);
`endif
    stall = m_ov && !bus.out_ready && rst_n;
    d = bus.in_data;
    prev_data = bus.out_data;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_ov = 1'b0;
      m_af = 1'b0;
      prev_stall = 1'b0;
    end else begin
      m_ov = ((sz - int'(o)) != 0);
      if (o) void'(q.pop_front());
      if (p) begin
        q.push_back(d);
        m_pushes++;
      end
      m_af = (q.size() >= 60);
      prev_stall = stall;
    end
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && (q.size() > 0 || m_ov); i++) tick();
    chk("drain_done", q.size(), 0);
  endtask

  typedef struct {
    bit            iv;
    logic [DW-1:0] id;
    bit            ordy;
    bit            e_irdy;
    bit            e_ov;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with a push attempt that must be ignored.
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);

    // Three bytes through an empty FIFO: latency and ordering.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = tbl[i].id;
      bus.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_irdy);
      chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].e_data);
      tick();
    end

    // Fill to full with the consumer stalled, then keep offering data.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.in_data = 8'(i);
      tick();
    end
    chk("full_in_ready", bus.in_ready, 0);
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    chk("full_level", bus.level, 64);
`endif
    bus.in_data = 8'hEE;
    repeat (3) tick();

    // At full: continuous one-in/one-out across the address wrap.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 130; i++) begin
      bus.in_data = 8'(8'h40 + i);
      tick();
    end
    drain();

    // Randomized 200-byte stream with random backpressure.
    m_pushes = 0;
    for (int c = 0; c < 5000 && m_pushes < 200; c++) begin
      bus.in_valid  = (m_pushes < 200) && ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    chk("stream_len", m_pushes, 200);
    drain();

    // Reset mid-operation with ten words stored.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'(8'hC0 + i);
      tick();
    end
    rst_n = 1'b0;
    bus.in_data = 8'h5A;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    chk("rst_mid_level", bus.level, 0);
`endif
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("a5_valid", bus.out_valid, 1);
    chk("a5_data", bus.out_data, 8'hA5);
    drain();

`ifdef RAM_FIFO_CTRL_LEVEL_EN
    // Almost-full threshold and its release after one pop.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.in_data = 8'(i * 3);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("af_set", bus.almost_full, 1);
    chk("af_level", bus.level, 60);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("af_clear", bus.almost_full, 0);
    chk("af_level_pop", bus.level, 59);
    drain();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
